// File: rtl/adder_share_arb_if.sv
// Handshake bundle between the requesting lanes and the shared-adder arbiter:
// NREQ operand request channels in, one tagged sum response channel out.
interface adder_share_arb_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH:0]        rsp_sum;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );

endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder between NREQ requesters; the granted
// operand pair is summed and held in a single-entry result register.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   x
);
  assign x = {1'b0, a} + {1'b0, b};
endmodule

module adder_share_arb #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  adder_share_arb_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]     state_q,   state_d;
  logic [IDW-1:0] rr_ptr_q,  rr_ptr_d;
  logic [WIDTH:0] rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0] rsp_id_q,  rsp_id_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   sel;
  logic             can_accept;
  logic             grant;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
  end

  // Scan from rr_ptr upwards (mod NREQ); the first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + 32'(k)) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A held result blocks new grants until the consumer drains it.
  assign can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;
  assign grant      = can_accept && found && !rst;
  assign sel        = grant ? winner : '0;
  assign op_a       = a_arr[sel];
  assign op_b       = b_arr[sel];

  adder #(.WIDTH(WIDTH)) u_adder (
    .a (op_a),
    .b (op_b),
    .x (sum)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_sum_d = rsp_sum_q;
    rsp_id_d  = rsp_id_q;
    if (grant) begin
      state_d   = ST_FULL;
      rsp_sum_d = sum;
      rsp_id_d  = winner;
      rr_ptr_d  = IDW'((32'(winner) + 32'd1) % NREQ);
    end else if (state_q == ST_FULL && bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      state_q   <= ST_EMPTY;
      rr_ptr_q  <= '0;
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign bus.req_ready = grant ? (NREQ'(1) << winner) : '0;
  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.busy      = (state_q == ST_FULL);
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one `adder` instance between NREQ independent requesters.
- Each requester offers an operand pair through a valid/ready handshake.
- The block grants one requester per cycle, feeds the granted pair through the shared adder and registers the sum.
- The result is returned with the requester ID on a single valid/ready response channel.
- Sits between the requesting compute lanes and the single `adder` datapath.

Parameters:
- WIDTH, 4, operand width; sum width is WIDTH+1, matching `adder`.
- NREQ, 4, number of requesters, 2..8.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  NREQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  packed operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; acceptance when req_valid[i] && req_ready[i].
- rsp_valid  output  1  result register holds an unconsumed sum.
- rsp_ready  input  1  downstream accepts the response.
- rsp_sum  output  WIDTH+1  registered a+b from the shared adder; MSB is carry-out.
- rsp_id  output  IDW  index of the requester that produced rsp_sum.
- busy  output  1  equals rsp_valid; provided for status.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, state=EMPTY.
  - req_ready is 0 during the reset cycle regardless of req_valid.
- The shared `adder` is instantiated inside the block. Its inputs are driven by the combinational mux of the winning requester's req_a/req_b. The mux selects requester 0 when nothing is granted.
- State machine, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) || rsp_ready.
- Winner selection, combinational: first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
- req_ready[winner]=1 only when can_accept and some req_valid is set; all other bits are 0. req_ready never depends on rsp_valid of another cycle beyond can_accept.
- On acceptance at edge k:
  - rsp_sum <= adder x.
  - rsp_id <= winner.
  - rsp_valid <= 1; state goes to FULL.
  - rr_ptr <= (winner+1) mod NREQ.
  - Latency is 1 cycle: the response is visible in cycle k+1.
- FULL and rsp_ready=1 with no new acceptance: rsp_valid <= 0, state goes to EMPTY.
- FULL and rsp_ready=1 with a simultaneous acceptance: the new result overwrites the register and stays FULL. This gives full throughput of one operation per cycle.
- FULL and rsp_ready=0: rsp_sum, rsp_id and rsp_valid hold stable, and req_ready is all zero (back-pressure).
- rr_ptr changes only on acceptance. An idle cycle or a stall does not rotate priority.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,…,NREQ-1,0,…
- Requester obligations: hold req_valid and operands stable until accepted. A requester that drops valid before grant is simply not selected.
- Arithmetic: rsp_sum = {1'b0,a} + {1'b0,b}, taken straight from the adder. There is no saturation; the carry appears in bit WIDTH, e.g. 15+15=30=5'b11110.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 the following cycle), no grant is issued in the reset cycle, and rr_ptr returns to 0.
- rsp_ready while EMPTY is ignored.

Test Plan:
- Reset then single request: rst high 2 cycles, low. Then req_valid=4'b0100 with a2=3, b2=9. Expect req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_sum=12, rsp_id=2, rr_ptr=3.
- Carry boundary: requester 0 sends a=15, b=15, then a=15, b=1. Expect rsp_sum=30 then 16, both with rsp_id=0.
- Round-robin: all four valid continuously, each with a=i, b=i, rsp_ready=1. Expect grants 0,1,2,3,0 on consecutive cycles, rsp_id sequence 0,1,2,3,0, sums 0,2,4,6,0, with no idle cycles.
- Back-pressure: a response is pending with rsp_ready=0 for 3 cycles while req_valid=4'b1111. Expect req_ready=0 and rsp_sum/rsp_id stable. Raise rsp_ready and expect the next grant the same cycle, to the requester at rr_ptr.
- Skip idle requesters: rr_ptr=1, req_valid=4'b1001. Expect grant to 3, then rr_ptr=0, then grant to 0.
- Reset mid-stream: assert rst while rsp_valid=1 and req_valid=4'b0010. Expect req_ready=0 that cycle and rsp_valid=0 after. After release, the first grant goes to 1 and the scan starts from rr_ptr=0.
